// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: drives one shared full-adder cell LSB first,
// one bit per clock, with a start/busy/done handshake and registered results.
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sr, r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry, r_busy, r_done, r_cout, r_ovf;

  logic w_s, w_c, w_last;

  // The single shared full-adder cell.
  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last = (r_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sr    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sr    <= {w_s, r_sr[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            // On the MSB cycle r_carry already holds the carry into the MSB.
            r_sum   <= {w_s, r_sr[WIDTH-1:1]};
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int total = 0, bad = 0, done_cnt = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] r;
    exp_t       e;
    r    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s  = r[W-1:0];
    e.co = r[W];
    e.ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov);
    exp_t e;
    e.s = s; e.co = co; e.ov = ov;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got=done want=no_done sum=%0h", sum);
      end else begin
        e = q.pop_front();
        chk("sum",  32'(sum),  32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
        chk("ovf",  32'(ovf),  32'(e.ov));
      end
    end
  end

  // Present a request for one cycle, then scramble the inputs to prove isolation.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input exp_t e);
    q.push_back(e);
    a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_done(input string nm, output int cyc, output int bcyc);
    cyc = 0; bcyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
    end while (!done && cyc < 40);
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout: got=no_done want=done", nm);
    end
  endtask

  initial begin
    int cyc, bcyc, dc;
    logic [W-1:0] x, y;
    logic ci;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum",  32'(sum),  0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf",  32'(ovf),  0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // 0+0: busy for W cycles, done in cycle W+1
    issue(8'h00, 8'h00, 1'b0, mk(8'h00, 1'b0, 1'b0));
    wait_done("zero", cyc, bcyc);
    chk("lat_cycles",  32'(cyc),  W+1);
    chk("busy_cycles", 32'(bcyc), W);

    issue(8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0));
    wait_done("ff_01", cyc, bcyc);
    issue(8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1));
    wait_done("7f_01", cyc, bcyc);
    issue(8'h80, 8'h80, 1'b1, mk(8'h01, 1'b1, 1'b1));
    wait_done("80_80", cyc, bcyc);
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 0);
    chk("hold_sum_idle", 32'(sum), 32'h01);

    // Start while busy is ignored
    dc = done_cnt;
    issue(8'h12, 8'h34, 1'b0, mk(8'h46, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", cyc, bcyc);
    chk("ignore_latency", 32'(cyc), W+1-3);
    repeat (W+3) @(negedge clk);
    chk("ignore_done_once", 32'(done_cnt - dc), 1);

    // Back-to-back: start asserted in the DONE cycle
    issue(8'h0F, 8'h01, 1'b0, mk(8'h10, 1'b0, 1'b0));
    wait_done("b2b_a", cyc, bcyc);
    issue(8'hC0, 8'h50, 1'b1, mk(8'h11, 1'b1, 1'b0));
    wait_done("b2b_b", cyc, bcyc);
    chk("b2b_spacing", 32'(cyc), W+1);

    // Reset mid-RUN discards the partial result
    a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("run_busy",  32'(busy), 1);
    chk("run_hold_sum", 32'(sum), 32'h11);
    dc = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_sum",  32'(sum),  0);
    chk("midrst_cout", 32'(cout), 0);
    chk("midrst_ovf",  32'(ovf),  0);
    repeat (W+4) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - dc), 0);
    chk("midrst_idle_busy", 32'(busy), 0);

    // Sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
      issue(x, y, ci, model(x, y, ci));
      wait_done("sweep", cyc, bcyc);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
